fast_frame_ctrl: RTL and testbench

- Frame-level sequencer for the FAST corner datapath (fast_top).
- Sits between the 7x7 window generator and fast_top: tracks the raster position of each window, issues only interior windows to fast_top, and tags each issued window with its (x,y).
- Pairs fast_top results with tags in order and emits a ready/valid keypoint stream (x, y, score) through an output FIFO.
- Enforces a per-frame keypoint budget and reports frame status.

---
 rtl/fast_frame_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_fast_frame_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_frame_ctrl.sv
// Frame sequencer for the FAST corner datapath: issues interior windows to fast_top,
// tags them with (x,y), and streams budgeted keypoints out through a FWFT FIFO.
module fast_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int X_W        = 11,
  parameter int Y_W        = 11,
  parameter int TAG_DEPTH  = 8,
  parameter int KP_DEPTH   = 16,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [X_W-1:0]        cfg_width,
  input  logic [Y_W-1:0]        cfg_height,
  input  logic [DATA_WIDTH-1:0] cfg_threshold,
  input  logic [CNT_W-1:0]      cfg_max_kp,
  input  logic                  win_valid_in,
  output logic                  fast_window_valid,
  output logic [DATA_WIDTH-1:0] fast_threshold,
  input  logic                  fast_out_valid,
  input  logic                  fast_is_corner,
  input  logic [DATA_WIDTH-1:0] fast_score,
  output logic                  kp_valid,
  input  logic                  kp_ready,
  output logic [X_W-1:0]        kp_x,
  output logic [Y_W-1:0]        kp_y,
  output logic [DATA_WIDTH-1:0] kp_score,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_W-1:0]      kp_count,
  output logic [CNT_W-1:0]      kp_dropped,
  output logic                  tag_err
);

  localparam int TAG_AW = $clog2(TAG_DEPTH);
  localparam int KP_AW  = $clog2(KP_DEPTH);
  localparam int TAG_W  = X_W + Y_W;
  localparam int KP_W   = X_W + Y_W + DATA_WIDTH;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic [X_W-1:0]        width_q;
  logic [Y_W-1:0]        height_q;
  logic [CNT_W-1:0]      max_kp_q;
  logic [X_W-1:0]        x_cnt;
  logic [Y_W-1:0]        y_cnt;
  logic                  start_acc, win_acc, x_last, y_last, interior;

  logic [TAG_W-1:0]      tag_mem [TAG_DEPTH];
  logic [TAG_AW:0]       tag_wr_ptr, tag_rd_ptr;
  logic                  tag_empty, tag_full, tag_push, tag_pop, tag_fault;
  logic [TAG_W-1:0]      tag_head;

  logic [KP_W-1:0]       kp_mem [KP_DEPTH];
  logic [KP_AW:0]        kp_wr_ptr, kp_rd_ptr;
  logic                  kp_empty, kp_full, kp_pop, kp_write, kp_drop, budget_hit, corner_in;
  logic [KP_W-1:0]       kp_head;

  assign start_acc = frame_start && (state == IDLE);
  assign win_acc   = win_valid_in && (state == RUN);
  assign x_last    = (x_cnt == width_q - X_W'(1));
  assign y_last    = (y_cnt == height_q - Y_W'(1));
  assign interior  = (x_cnt >= X_W'(3)) && (x_cnt <= width_q - X_W'(4)) &&
                     (y_cnt >= Y_W'(3)) && (y_cnt <= height_q - Y_W'(4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (frame_start) state_next = RUN;
      RUN:     if (win_valid_in && x_last && y_last) state_next = DRAIN;
      DRAIN:   if (tag_empty) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy              = (state != IDLE);
    frame_done        = (state == DONE);
    fast_window_valid = win_acc && interior;
  end

  // Frame configuration is frozen at frame start so mid-frame cfg changes are harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_q        <= '0;
      height_q       <= '0;
      fast_threshold <= '0;
      max_kp_q       <= '0;
      x_cnt          <= '0;
      y_cnt          <= '0;
    end else if (start_acc) begin
      width_q        <= cfg_width;
      height_q       <= cfg_height;
      fast_threshold <= cfg_threshold;
      max_kp_q       <= cfg_max_kp;
      x_cnt          <= '0;
      y_cnt          <= '0;
    end else if (win_acc) begin
      if (x_last) begin
        x_cnt <= '0;
        y_cnt <= y_last ? '0 : y_cnt + Y_W'(1);
      end else begin
        x_cnt <= x_cnt + X_W'(1);
      end
    end
  end

  assign tag_empty = (tag_wr_ptr == tag_rd_ptr);
  assign tag_full  = (tag_wr_ptr[TAG_AW] != tag_rd_ptr[TAG_AW]) &&
                     (tag_wr_ptr[TAG_AW-1:0] == tag_rd_ptr[TAG_AW-1:0]);
  assign tag_pop   = fast_out_valid && !tag_empty;
  assign tag_push  = fast_window_valid && (!tag_full || tag_pop);
  assign tag_fault = (fast_window_valid && tag_full && !tag_pop) || (fast_out_valid && tag_empty);
  assign tag_head  = tag_mem[tag_rd_ptr[TAG_AW-1:0]];

  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[tag_wr_ptr[TAG_AW-1:0]] <= {x_cnt, y_cnt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
    end else begin
      if (tag_push) tag_wr_ptr <= tag_wr_ptr + (TAG_AW+1)'(1);
      if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + (TAG_AW+1)'(1);
    end
  end

  // A full KP FIFO still takes a write when the consumer drains it in the same cycle.
  assign kp_empty   = (kp_wr_ptr == kp_rd_ptr);
  assign kp_full    = (kp_wr_ptr[KP_AW] != kp_rd_ptr[KP_AW]) &&
                      (kp_wr_ptr[KP_AW-1:0] == kp_rd_ptr[KP_AW-1:0]);
  assign kp_pop     = !kp_empty && kp_ready;
  assign corner_in  = tag_pop && fast_is_corner;
  assign budget_hit = (max_kp_q != '0) && (kp_count == max_kp_q);
  assign kp_write   = corner_in && !budget_hit && (!kp_full || kp_pop);
  assign kp_drop    = corner_in && !kp_write;
  assign kp_head    = kp_mem[kp_rd_ptr[KP_AW-1:0]];

  always_ff @(posedge clk) begin
    if (kp_write) kp_mem[kp_wr_ptr[KP_AW-1:0]] <= {tag_head, fast_score};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp_wr_ptr <= '0;
      kp_rd_ptr <= '0;
    end else begin
      if (kp_write) kp_wr_ptr <= kp_wr_ptr + (KP_AW+1)'(1);
      if (kp_pop)   kp_rd_ptr <= kp_rd_ptr + (KP_AW+1)'(1);
    end
  end

  always_comb begin
    kp_valid = !kp_empty;
    kp_x     = kp_valid ? kp_head[KP_W-1 -: X_W] : '0;
    kp_y     = kp_valid ? kp_head[DATA_WIDTH +: Y_W] : '0;
    kp_score = kp_valid ? kp_head[DATA_WIDTH-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kp_count   <= '0;
      kp_dropped <= '0;
      tag_err    <= 1'b0;
    end else if (start_acc) begin
      kp_count   <= '0;
      kp_dropped <= '0;
      tag_err    <= 1'b0;
    end else begin
      if (kp_write && kp_count != CNT_MAX)  kp_count   <= kp_count + CNT_W'(1);
      if (kp_drop && kp_dropped != CNT_MAX) kp_dropped <= kp_dropped + CNT_W'(1);
      if (tag_fault)                        tag_err    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fast_frame_ctrl.sv
// Testbench for fast_frame_ctrl: emulates the window generator, an in-order fast_top and
// the keypoint consumer, and checks against a raster-order reference model.
module tb_fast_frame_ctrl;

  localparam int DW  = 8;
  localparam int XW  = 11;
  localparam int YW  = 11;
  localparam int CW  = 16;
  localparam int BIG = 1 << 30;

  typedef struct {
    int due;
    bit c;
    int s;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_start;
  logic [XW-1:0] cfg_width;
  logic [YW-1:0] cfg_height;
  logic [DW-1:0] cfg_threshold;
  logic [CW-1:0] cfg_max_kp;
  logic          win_valid_in;
  logic          fast_window_valid;
  logic [DW-1:0] fast_threshold;
  logic          fast_out_valid;
  logic          fast_is_corner;
  logic [DW-1:0] fast_score;
  logic          kp_valid;
  logic          kp_ready;
  logic [XW-1:0] kp_x;
  logic [YW-1:0] kp_y;
  logic [DW-1:0] kp_score;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] kp_count;
  logic [CW-1:0] kp_dropped;
  logic          tag_err;

  int total_cmp = 0;
  int bad_cmp   = 0;

  int cmap [32][32];
  logic [XW+YW-1:0]    issued[$];
  logic [XW+YW-1:0]    exp_issued[$];
  logic [XW+YW+DW-1:0] got[$];
  logic [XW+YW+DW-1:0] exp_kp[$];
  res_t pend[$];
  int done_cnt, done_cyc, last_res_cyc, last_win_cyc;
  bit timed_out;

  always #5 clk = ~clk;

  fast_frame_ctrl #(
    .DATA_WIDTH(DW), .X_W(XW), .Y_W(YW), .TAG_DEPTH(8), .KP_DEPTH(16), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_threshold(cfg_threshold),
    .cfg_max_kp(cfg_max_kp), .win_valid_in(win_valid_in),
    .fast_window_valid(fast_window_valid), .fast_threshold(fast_threshold),
    .fast_out_valid(fast_out_valid), .fast_is_corner(fast_is_corner), .fast_score(fast_score),
    .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_x(kp_x), .kp_y(kp_y), .kp_score(kp_score),
    .busy(busy), .frame_done(frame_done), .kp_count(kp_count), .kp_dropped(kp_dropped),
    .tag_err(tag_err)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at time %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  function automatic void clear_map();
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++) cmap[x][y] = 0;
  endfunction

  // Reference: interior windows in raster order; corners accepted until budget or capacity.
  task automatic model_frame(input int w, input int h, input int thr, input int maxkp,
                             input int cap, output int kept, output int dropped);
    exp_issued.delete();
    exp_kp.delete();
    kept = 0;
    dropped = 0;
    for (int y = 3; y <= h - 4; y++)
      for (int x = 3; x <= w - 4; x++) begin
        exp_issued.push_back({XW'(x), YW'(y)});
        if (cmap[x][y] > thr) begin
          if ((maxkp != 0 && kept >= maxkp) || kept >= cap) dropped++;
          else begin
            kept++;
            exp_kp.push_back({XW'(x), YW'(y), DW'(cmap[x][y])});
          end
        end
      end
  endtask

  // rmode: 0 consumer never ready, 1 always ready, 2 random ready.
  task automatic run_frame(input int w, input int h, input int thr, input int maxkp,
                           input int lat, input int rmode, input int gap,
                           input int mid_at, input int stop_after);
    int cyc, sent, bx, by;
    res_t r;
    issued.delete(); got.delete(); pend.delete();
    done_cnt = 0; done_cyc = -1; last_res_cyc = -1; last_win_cyc = -1; timed_out = 0;
    cyc = 0; sent = 0; bx = 0; by = 0;
    @(negedge clk);
    cfg_width = XW'(w); cfg_height = YW'(h); cfg_threshold = DW'(thr); cfg_max_kp = CW'(maxkp);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    forever begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        fast_out_valid = 1'b1; fast_is_corner = r.c; fast_score = DW'(r.s);
        last_res_cyc = cyc;
      end else begin
        fast_out_valid = 1'b0; fast_is_corner = 1'b0; fast_score = '0;
      end
      win_valid_in = (sent < w * h) && ($urandom_range(99) >= gap);
      frame_start  = (cyc == mid_at);
      kp_ready     = (rmode == 1) || (rmode == 2 && $urandom_range(1) == 1);
      #1;
      if (win_valid_in) begin
        if (fast_window_valid) begin
          issued.push_back({XW'(bx), YW'(by)});
          r.due = cyc + lat;
          r.c   = (cmap[bx][by] > int'(fast_threshold));
          r.s   = cmap[bx][by];
          pend.push_back(r);
        end
        sent++;
        if (sent == w * h) last_win_cyc = cyc;
        bx++;
        if (bx == w) begin bx = 0; by++; end
      end
      if (kp_valid && kp_ready) got.push_back({kp_x, kp_y, kp_score});
      if (frame_done) begin done_cnt++; done_cyc = cyc; end
      @(negedge clk);
      cyc++;
      if (done_cnt > 0 && (rmode == 0 || !kp_valid)) break;
      if (stop_after > 0 && sent >= stop_after) break;
      if (cyc >= 3000) begin timed_out = 1; break; end
    end
    win_valid_in = 1'b0; fast_out_valid = 1'b0; fast_is_corner = 1'b0;
    fast_score = '0; frame_start = 1'b0; kp_ready = 1'b0;
  endtask

  function automatic bit kp_list_differs();
    bit d = (got.size() != exp_kp.size());
    foreach (exp_kp[i]) if (i < got.size() && got[i] !== exp_kp[i]) d = 1;
    return d;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; frame_start = 1'b0; win_valid_in = 1'b1; fast_out_valid = 1'b0;
    fast_is_corner = 1'b0; fast_score = '0; kp_ready = 1'b0;
    cfg_width = '0; cfg_height = '0; cfg_threshold = '0; cfg_max_kp = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    total_cmp++;
    if ({busy, kp_valid, frame_done, tag_err, fast_window_valid} !== 5'b0) begin
      bad_cmp++; $display("[TB] FAIL reset_flags got=%b want=00000",
                          {busy, kp_valid, frame_done, tag_err, fast_window_valid});
    end
    total_cmp++;
    if ({kp_count, kp_dropped, fast_threshold, kp_x} !== '0) begin
      bad_cmp++; $display("[TB] FAIL reset_values cnt=%0d drop=%0d thr=%0d x=%0d want 0",
                          kp_count, kp_dropped, fast_threshold, kp_x);
    end
    win_valid_in = 1'b0;
  endtask

  task automatic test_single_corner();
    int kept, dropped;
    clear_map(); cmap[5][4] = 21;
    model_frame(16, 8, 20, 0, BIG, kept, dropped);
    run_frame(16, 8, 20, 0, 3, 1, 0, -1, 0);
    total_cmp++;
    if (timed_out || kp_list_differs()) begin
      bad_cmp++; $display("[TB] FAIL t1_kp_list got n=%0d first=%h want n=%0d first=%h timeout=%0d",
                          got.size(), got.size() ? got[0] : 0, exp_kp.size(), exp_kp[0], timed_out);
    end
    total_cmp++;
    if (kp_count !== CW'(1) || kp_dropped !== CW'(0)) begin
      bad_cmp++; $display("[TB] FAIL t1_counts cnt=%0d drop=%0d want 1/0", kp_count, kp_dropped);
    end
    total_cmp++;
    if (done_cnt !== 1 || done_cyc !== ((last_win_cyc > last_res_cyc ? last_win_cyc : last_res_cyc) + 2)) begin
      bad_cmp++; $display("[TB] FAIL t1_frame_done n=%0d cyc=%0d want n=1 cyc=%0d", done_cnt, done_cyc,
                          (last_win_cyc > last_res_cyc ? last_win_cyc : last_res_cyc) + 2);
    end
    total_cmp++;
    if (fast_threshold !== DW'(20) || tag_err !== 1'b0 || busy !== 1'b0) begin
      bad_cmp++; $display("[TB] FAIL t1_status thr=%0d err=%0d busy=%0d want 20/0/0",
                          fast_threshold, tag_err, busy);
    end
  endtask

  task automatic test_interior_windows();
    int kept, dropped;
    clear_map();
    model_frame(16, 8, 20, 0, BIG, kept, dropped);
    run_frame(16, 8, 20, 0, 2, 1, 30, -1, 0);
    total_cmp++;
    if (issued.size() !== 20) begin
      bad_cmp++; $display("[TB] FAIL t2_issue_count got=%0d want=20", issued.size());
    end
    total_cmp++;
    if (issued.size() != exp_issued.size() || timed_out) begin
      bad_cmp++; $display("[TB] FAIL t2_issue_list size got=%0d want=%0d", issued.size(), exp_issued.size());
    end else begin
      foreach (exp_issued[i])
        if (issued[i] !== exp_issued[i]) begin
          bad_cmp++; $display("[TB] FAIL t2_issue_pos idx=%0d got=%h want=%h", i, issued[i], exp_issued[i]);
          break;
        end
    end
    total_cmp++;
    if (got.size() !== 0 || kp_count !== CW'(0)) begin
      bad_cmp++; $display("[TB] FAIL t2_no_kp got=%0d cnt=%0d want 0/0", got.size(), kp_count);
    end
  endtask

  task automatic test_budget();
    int kept, dropped;
    clear_map();
    for (int y = 3; y <= 4; y++) for (int x = 3; x <= 12; x++) cmap[x][y] = $urandom_range(21, 200);
    model_frame(16, 8, 20, 5, BIG, kept, dropped);
    run_frame(16, 8, 20, 5, 4, 1, 10, -1, 0);
    total_cmp++;
    if (timed_out || kp_list_differs()) begin
      bad_cmp++; $display("[TB] FAIL t3_kp_list got n=%0d want n=%0d", got.size(), exp_kp.size());
    end
    total_cmp++;
    if (kp_count !== CW'(5) || kp_dropped !== CW'(15)) begin
      bad_cmp++; $display("[TB] FAIL t3_counts cnt=%0d drop=%0d want 5/15", kp_count, kp_dropped);
    end
  endtask

  task automatic test_backpressure();
    int kept, dropped;
    clear_map();
    for (int y = 3; y <= 4; y++) for (int x = 3; x <= 12; x++) cmap[x][y] = $urandom_range(21, 255);
    model_frame(16, 8, 20, 0, 16, kept, dropped);
    run_frame(16, 8, 20, 0, 3, 0, 0, -1, 0);
    total_cmp++;
    if (kp_count !== CW'(16) || kp_dropped !== CW'(4) || kp_valid !== 1'b1 || got.size() != 0) begin
      bad_cmp++; $display("[TB] FAIL t4_full cnt=%0d drop=%0d valid=%0d want 16/4/1",
                          kp_count, kp_dropped, kp_valid);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      kp_ready = 1'b1;
      #1;
      if (kp_valid) got.push_back({kp_x, kp_y, kp_score});
    end
    @(negedge clk);
    kp_ready = 1'b0;
    total_cmp++;
    if (kp_list_differs()) begin
      bad_cmp++; $display("[TB] FAIL t4_drain got n=%0d want n=%0d", got.size(), exp_kp.size());
    end
  endtask

  task automatic test_restart();
    int kept, dropped;
    clear_map(); cmap[5][4] = 21;
    model_frame(16, 8, 20, 0, BIG, kept, dropped);
    run_frame(16, 8, 20, 0, 3, 1, 0, 40, 0);
    total_cmp++;
    if (timed_out || kp_list_differs() || kp_count !== CW'(1) || done_cnt !== 1 ||
        done_cyc !== ((last_win_cyc > last_res_cyc ? last_win_cyc : last_res_cyc) + 2)) begin
      bad_cmp++; $display("[TB] FAIL t5_mid_start kp=%0d cnt=%0d done=%0d@%0d want 1/1/1",
                          got.size(), kp_count, done_cnt, done_cyc);
    end
    model_frame(16, 8, 30, 0, BIG, kept, dropped);
    run_frame(16, 8, 30, 0, 3, 1, 0, -1, 0);
    total_cmp++;
    if (timed_out || got.size() != 0 || kp_count !== CW'(0) || fast_threshold !== DW'(30)) begin
      bad_cmp++; $display("[TB] FAIL t5_thr30 kp=%0d cnt=%0d thr=%0d want 0/0/30",
                          got.size(), kp_count, fast_threshold);
    end
  endtask

  task automatic test_midframe_reset();
    int kept, dropped;
    clear_map();
    for (int y = 3; y <= 4; y++) for (int x = 3; x <= 12; x++) cmap[x][y] = 50;
    run_frame(16, 8, 20, 0, 5, 0, 0, -1, 70);
    #1;
    total_cmp++;
    if (busy !== 1'b1 || kp_valid !== 1'b1) begin
      bad_cmp++; $display("[TB] FAIL t6_pre_reset busy=%0d kp_valid=%0d want 1/1", busy, kp_valid);
    end
    win_valid_in = 1'b1;
    rst_n = 1'b0;
    #1;
    total_cmp++;
    if ({busy, kp_valid, fast_window_valid, frame_done} !== 4'b0 ||
        {kp_count, kp_dropped, fast_threshold, kp_x, kp_y, kp_score} !== '0) begin
      bad_cmp++; $display("[TB] FAIL t6_reset busy=%0d kpv=%0d fwv=%0d cnt=%0d thr=%0d want all 0",
                          busy, kp_valid, fast_window_valid, kp_count, fast_threshold);
    end
    @(negedge clk);
    win_valid_in = 1'b0;
    rst_n = 1'b1;
    clear_map(); cmap[5][4] = 21;
    model_frame(16, 8, 20, 0, BIG, kept, dropped);
    run_frame(16, 8, 20, 0, 3, 1, 0, -1, 0);
    total_cmp++;
    if (timed_out || kp_list_differs() || kp_count !== CW'(1) || tag_err !== 1'b0) begin
      bad_cmp++; $display("[TB] FAIL t6_fresh kp=%0d cnt=%0d err=%0d want 1/1/0",
                          got.size(), kp_count, tag_err);
    end
  endtask

  task automatic test_random_frames();
    int w, h, thr, maxkp, lat, gap, kept, dropped;
    for (int f = 0; f < 4; f++) begin
      w = $urandom_range(7, 20); h = $urandom_range(7, 12);
      thr = $urandom_range(0, 40); maxkp = $urandom_range(0, 6);
      lat = $urandom_range(1, 6); gap = $urandom_range(0, 40);
      clear_map();
      for (int k = 0; k < 14; k++) cmap[$urandom_range(0, w - 1)][$urandom_range(0, h - 1)] = $urandom_range(1, 60);
      model_frame(w, h, thr, maxkp, BIG, kept, dropped);
      run_frame(w, h, thr, maxkp, lat, 2, gap, -1, 0);
      total_cmp++;
      if (timed_out || kp_list_differs() || done_cnt !== 1) begin
        bad_cmp++; $display("[TB] FAIL rnd%0d_kp_list %0dx%0d got n=%0d want n=%0d done=%0d",
                            f, w, h, got.size(), exp_kp.size(), done_cnt);
      end
      total_cmp++;
      if (kp_count !== CW'(kept) || kp_dropped !== CW'(dropped) || tag_err !== 1'b0) begin
        bad_cmp++; $display("[TB] FAIL rnd%0d_counts cnt=%0d drop=%0d err=%0d want %0d/%0d/0",
                            f, kp_count, kp_dropped, tag_err, kept, dropped);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_corner();
    test_interior_windows();
    test_budget();
    test_backpressure();
    test_restart();
    test_midframe_reset();
    test_random_frames();
    $display("test done: total=%0d bad=%0d", total_cmp, bad_cmp);
    $finish;
  end

endmodule
